// File: rtl/buf_pkg.sv
// -----------------------------------------------------------------------------
// buf_pkg
// Shared helpers for the buffering blocks (par_rw_fifo, fifo_ptr_ctr):
//   clog2    : ceiling log2 of a positive integer (constant-foldable)
//   ptr_w    : width of a pointer that indexes 0..depth-1 (at least 1 bit)
//   cnt_w    : width of an occupancy counter that holds 0..depth
//   mod_add  : (ptr + inc) mod depth for ptr < depth and inc <= depth, done
//              with a single compare-and-subtract so non-power-of-two depths
//              wrap correctly.
// -----------------------------------------------------------------------------
package buf_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Valid only for ptr < depth and inc <= depth, which every caller guarantees.
  function automatic int unsigned mod_add(input int unsigned ptr,
                                          input int unsigned inc,
                                          input int unsigned depth);
    int unsigned s;
    s = ptr + inc;
    return (s >= depth) ? (s - depth) : s;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctr
// Circular pointer that advances by STEP modulo DEPTH.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset (pointer -> 0)
//   clr  in  synchronous clear, wins over en
//   en   in  advance by STEP on the next rising edge
//   ptr  out current pointer value, 0..DEPTH-1
// -----------------------------------------------------------------------------
module fifo_ptr_ctr
  import buf_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int DEPTH = 12,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = PW'(mod_add(32'(ptr_q), STEP, DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/par_rw_fifo.sv
// -----------------------------------------------------------------------------
// par_rw_fifo
// Circular FIFO that accepts PAR_WRITE words per write handshake and delivers
// PAR_READ words per read handshake (show-ahead). Depth need not be a power
// of two. Re-packs filter / feature-map words between the input streamer and
// the CNN processing element.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   flush        in   synchronous clear of all content (beats any handshake)
//   wr_data      in   WIDTH*PAR_WRITE, word j at [j*WIDTH +: WIDTH], word 0 oldest
//   wr_valid     in   write request
//   wr_ready     out  room for PAR_WRITE more words
//   rd_data      out  WIDTH*PAR_READ, word k at [k*WIDTH +: WIDTH], word 0 oldest
//   rd_valid     out  at least PAR_READ words stored
//   rd_ready     in   consumer takes rd_data
//   count        out  occupancy in words
//   almost_full  out  count >= AF_LEVEL   (only with FIFO_WATERMARK_EN)
//   almost_empty out  count <= AE_LEVEL   (only with FIFO_WATERMARK_EN)
//
// Build option: define FIFO_WATERMARK_EN to add the watermark flags and the
// AF_LEVEL / AE_LEVEL parameters.
// -----------------------------------------------------------------------------
module par_rw_fifo
  import buf_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 12,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 3
`ifdef FIFO_WATERMARK_EN
  ,
  parameter int AF_LEVEL  = DEPTH - PAR_WRITE,
  parameter int AE_LEVEL  = PAR_READ
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [WIDTH*PAR_WRITE-1:0]    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [WIDTH*PAR_READ-1:0]     rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [cnt_w(DEPTH)-1:0]       count
`ifdef FIFO_WATERMARK_EN
  ,
  output logic                          almost_full,
  output logic                          almost_empty
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int EW = CW + 1;

  // wr_ready / rd_valid thresholds as count comparisons.
  localparam logic [CW-1:0] WR_LIMIT = CW'(DEPTH - PAR_WRITE);
  localparam logic [CW-1:0] RD_MIN   = CW'(PAR_READ);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_addr [PAR_WRITE];
  logic [PW-1:0] rd_addr [PAR_READ];

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [EW-1:0] count_ext;

  logic wr_fire;
  logic rd_fire;

  // Status depends only on the registered count.
  assign wr_ready = (count_q <= WR_LIMIT);
  assign rd_valid = (count_q >= RD_MIN);

  // Flush discards any handshake in the same cycle.
  assign wr_fire = wr_valid && wr_ready && !flush;
  assign rd_fire = rd_valid && rd_ready && !flush;

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  fifo_ptr_ctr #(
    .STEP  (PAR_WRITE),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (wr_fire),
    .ptr (wr_ptr)
  );

  fifo_ptr_ctr #(
    .STEP  (PAR_READ),
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (rd_fire),
    .ptr (rd_ptr)
  );

  // ---------------------------------------------------------------------------
  // Per-word addresses (wrap past the last entry, never a power-of-two mask)
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < PAR_WRITE; gi++) begin : g_wr_addr
      assign wr_addr[gi] = PW'(mod_add(32'(wr_ptr), gi, DEPTH));
    end
    for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_rd_addr
      assign rd_addr[gi] = PW'(mod_add(32'(rd_ptr), gi, DEPTH));
      // Show-ahead: the oldest PAR_READ words are always presented.
      assign rd_data[gi*WIDTH +: WIDTH] = mem_q[rd_addr[gi]];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage (not reset; content is only meaningful below count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < PAR_WRITE; j++) begin
        mem_q[wr_addr[j]] <= wr_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy: one extra bit so the add-then-subtract never overflows the
  // intermediate; the final value always lands in 0..DEPTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_ext = {1'b0, count_q};
    if (wr_fire) begin
      count_ext = count_ext + EW'(PAR_WRITE);
    end
    if (rd_fire) begin
      count_ext = count_ext - EW'(PAR_READ);
    end
    count_d = flush ? '0 : CW'(count_ext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef FIFO_WATERMARK_EN
  assign almost_full  = (32'(count_q) >= AF_LEVEL);
  assign almost_empty = (32'(count_q) <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_par_rw_fifo.sv
// -----------------------------------------------------------------------------
// tb_par_rw_fifo
// Self-checking bench for par_rw_fifo (WIDTH=16, DEPTH=12, PAR_WRITE=2,
// PAR_READ=3). A reference occupancy model predicts wr_ready / rd_valid /
// count; written words go into a scoreboard queue and are popped and compared
// against rd_data on every read handshake.
// -----------------------------------------------------------------------------
module tb_par_rw_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int NW    = 2;
  localparam int NR    = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [WIDTH*NW-1:0]   wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [WIDTH*NR-1:0]   rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [3:0]            count;
`ifdef FIFO_WATERMARK_EN
  logic                  almost_full;
  logic                  almost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_count = 0;
  int sbq[$];

  always #5 clk = ~clk;

  par_rw_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PAR_WRITE (NW),
    .PAR_READ  (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count)
`ifdef FIFO_WATERMARK_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  function automatic logic [WIDTH*NW-1:0] pack2(input int a, input int b);
    return {WIDTH'(b), WIDTH'(a)};
  endfunction

  // One clock of stimulus: drive at the falling edge, check status against
  // the model, then account for the handshakes the rising edge will commit.
  task automatic cycle(input bit wv, input logic [WIDTH*NW-1:0] wd,
                       input bit rr, input bit fl, output bit wf, output bit rf);
    bit m_wr_rdy;
    bit m_rd_vld;
    logic [WIDTH*NR-1:0] exp_rd;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    m_wr_rdy = (DEPTH - m_count) >= NW;
    m_rd_vld = m_count >= NR;
    n_cmp++;
    if (wr_ready !== m_wr_rdy) begin
      n_err++;
      $display("FAIL wr_ready: got %b want %b (model count %0d)", wr_ready, m_wr_rdy, m_count);
    end
    n_cmp++;
    if (rd_valid !== m_rd_vld) begin
      n_err++;
      $display("FAIL rd_valid: got %b want %b (model count %0d)", rd_valid, m_rd_vld, m_count);
    end
    n_cmp++;
    if (count !== 4'(m_count)) begin
      n_err++;
      $display("FAIL count: got %0d want %0d", count, m_count);
    end
    wf = wv && m_wr_rdy && !fl;
    rf = rr && m_rd_vld && !fl;
    if (rf) begin
      for (int k = 0; k < NR; k++) begin
        exp_rd[k*WIDTH +: WIDTH] = WIDTH'(sbq[k]);
      end
      n_cmp++;
      if (rd_data !== exp_rd) begin
        n_err++;
        $display("FAIL rd_data: got %h want %h", rd_data, exp_rd);
      end
      $display("rd  %0d %0d %0d  count=%0d", sbq[0], sbq[1], sbq[2], m_count);
      for (int k = 0; k < NR; k++) begin
        void'(sbq.pop_front());
      end
    end
    if (fl) begin
      $display("flush count=%0d", m_count);
      m_count = 0;
      sbq.delete();
    end else begin
      if (wf) begin
        sbq.push_back(int'(wd[WIDTH-1:0]));
        sbq.push_back(int'(wd[2*WIDTH-1:WIDTH]));
        $display("wr  %0d %0d  count=%0d", wd[WIDTH-1:0], wd[2*WIDTH-1:WIDTH], m_count);
      end
      m_count = m_count + (wf ? NW : 0) - (rf ? NR : 0);
    end
  endtask

  task automatic idle();
    bit wf, rf;
    cycle(1'b0, '0, 1'b0, 1'b0, wf, rf);
  endtask

  task automatic wr(input int a, input int b);
    bit wf, rf;
    cycle(1'b1, pack2(a, b), 1'b0, 1'b0, wf, rf);
  endtask

  task automatic rd();
    bit wf, rf;
    cycle(1'b0, '0, 1'b1, 1'b0, wf, rf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush = 1'b0;
    m_count = 0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data = '0;
    #12;
    n_cmp++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got count=%0d rd_valid=%b wr_ready=%b want 0/0/1",
               count, rd_valid, wr_ready);
    end
`ifdef FIFO_WATERMARK_EN
    n_cmp++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got ae=%b af=%b want 1/0", almost_empty, almost_full);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    m_count = 0;
    sbq.delete();
  endtask

  task automatic test_basic();
    wr(1, 2);
    wr(3, 4);
    rd();       // rd_valid=1 and rd_data={1,2,3} checked here
    idle();     // count=1, rd_valid=0 checked here
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(2*i + 1, 2*i + 2);
    end
    for (int i = 0; i < 5; i++) begin
      wr(99, 98);   // ignored while full
    end
    n_cmp++;
    if (count !== 4'd12) begin
      n_err++;
      $display("FAIL full_hold_count: got %0d want 12", count);
    end
    for (int i = 0; i < 4; i++) begin
      rd();
    end
    idle();
  endtask

  task automatic test_stream();
    int nw;
    int nreads;
    int guard;
    bit wv, rr, wf, rf;
    do_reset();
    nw = 0;
    nreads = 0;
    guard = 0;
    while ((nw < 60 || m_count >= NR) && guard < 3000) begin
      wv = (nw < 60) && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 3) != 0);
      cycle(wv, pack2(100 + nw, 101 + nw), rr, 1'b0, wf, rf);
      if (wf) nw += NW;
      if (rf) nreads++;
      n_cmp++;
      if (count > 4'd12) begin
        n_err++;
        $display("FAIL stream_bound: got count %0d want <= 12", count);
      end
      guard++;
    end
    n_cmp++;
    if (nreads != 20 || guard >= 3000) begin
      n_err++;
      $display("FAIL stream_done: got %0d reads in %0d cycles want 20 reads", nreads, guard);
    end
    idle();
  endtask

  task automatic test_overlap();
    bit wf, rf;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(20 + 2*i, 21 + 2*i);
    end
    rd();                                          // count 8 -> 5
    cycle(1'b1, pack2(28, 29), 1'b1, 1'b0, wf, rf); // 5 -> 4
    n_cmp++;
    if (!(wf && rf)) begin
      n_err++;
      $display("FAIL overlap_fire: got wf=%b rf=%b want 1/1", wf, rf);
    end
    rd();
    idle();
  endtask

  task automatic test_flush();
    bit wf, rf;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(40 + i, 50 + i);
    end
    cycle(1'b1, pack2(77, 78), 1'b0, 1'b1, wf, rf);
    idle();   // count=0, rd_valid=0, wr_ready=1 checked here
    wr(7, 8);
    wr(9, 10);
    rd();     // must return 7, 8, 9
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(60 + i, 70 + i);
    end
    rd();
    idle();   // count 9 confirmed here
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;       // still well before the next rising edge
    n_cmp++;
    if (count !== 4'd0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got count=%0d rd_valid=%b want 0/0", count, rd_valid);
    end
`ifdef FIFO_WATERMARK_EN
    n_cmp++;
    if (almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_ae: got %b want 1", almost_empty);
    end
`endif
    m_count = 0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_overlap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
